// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control block: opcodes,
// FSM states, branch one-hot positions and alu_control field layout.
package ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    // One-hot branch_type bit positions: {bgeu,bltu,bge,blt,bne,beq}
    localparam int BR_BEQ  = 0;
    localparam int BR_BNE  = 1;
    localparam int BR_BLT  = 2;
    localparam int BR_BGE  = 3;
    localparam int BR_BLTU = 4;
    localparam int BR_BGEU = 5;
    localparam int BR_W    = 6;

    // alu_control layout: {zeros, imm_sel, alt, funct3}
    localparam int ALU_F3_LSB  = 0;
    localparam int ALU_F3_MSB  = 2;
    localparam int ALU_ALT_BIT = 3;
    localparam int ALU_IMM_BIT = 4;
    localparam int ALU_BASE_W  = 5;

    typedef struct packed {
        logic [ALU_BASE_W-1:0] alu;
        logic [BR_W-1:0]       branch;
        logic                  is_load;
        logic                  is_store;
        logic                  is_lui;
        logic                  is_jump;
        logic                  is_branch;
        logic                  illegal;
    } decode_t;

    // Pack the three alu_control fields into their bit positions.
    function automatic logic [ALU_BASE_W-1:0] alu_code(input logic       imm_sel,
                                                       input logic       alt,
                                                       input logic [2:0] funct3);
        logic [ALU_BASE_W-1:0] code;
        code                         = '0;
        code[ALU_IMM_BIT]            = imm_sel;
        code[ALU_ALT_BIT]            = alt;
        code[ALU_F3_MSB:ALU_F3_LSB]  = funct3;
        return code;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32I decoder: turns an instruction word into
// alu_control, branch one-hot, class flags and an illegal indication.
module instr_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output decode_t     o_dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_is_shift;
    logic       w_unused_fields;

    assign w_opcode   = i_instr[6:0];
    assign w_funct3   = i_instr[14:12];
    assign w_funct7   = i_instr[31:25];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    // Register specifiers and immediates are not needed for control.
    assign w_unused_fields = ^{i_instr[24:15], i_instr[11:7]};

    // Opcode/funct driven decode; anything not listed is illegal.
    always_comb begin
        o_dec = '0;
        unique case (w_opcode)
            OP_RTYPE: begin
                o_dec.alu = alu_code(1'b0, w_funct7[5], w_funct3);
                if ((w_funct7 != F7_BASE) && (w_funct7 != F7_ALT)) begin
                    o_dec.illegal = 1'b1;
                end else if ((w_funct7 == F7_ALT) &&
                             (w_funct3 != 3'b000) && (w_funct3 != 3'b101)) begin
                    o_dec.illegal = 1'b1;
                end
            end
            OP_ITYPE: begin
                o_dec.alu = alu_code(1'b1, w_is_shift ? w_funct7[5] : 1'b0, w_funct3);
            end
            OP_LOAD: begin
                o_dec.alu     = alu_code(1'b1, 1'b0, 3'b000);
                o_dec.is_load = 1'b1;
            end
            OP_STORE: begin
                o_dec.alu      = alu_code(1'b1, 1'b0, 3'b000);
                o_dec.is_store = 1'b1;
            end
            OP_LUI: begin
                o_dec.alu    = alu_code(1'b1, 1'b0, 3'b000);
                o_dec.is_lui = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                o_dec.alu     = alu_code(1'b1, 1'b0, 3'b000);
                o_dec.is_jump = 1'b1;
            end
            OP_BRANCH: begin
                o_dec.alu       = alu_code(1'b0, 1'b0, w_funct3);
                o_dec.is_branch = 1'b1;
                unique case (w_funct3)
                    3'b000:  o_dec.branch[BR_BEQ]  = 1'b1;
                    3'b001:  o_dec.branch[BR_BNE]  = 1'b1;
                    3'b100:  o_dec.branch[BR_BLT]  = 1'b1;
                    3'b101:  o_dec.branch[BR_BGE]  = 1'b1;
                    3'b110:  o_dec.branch[BR_BLTU] = 1'b1;
                    3'b111:  o_dec.branch[BR_BGEU] = 1'b1;
                    default: o_dec.illegal         = 1'b1;
                endcase
            end
            default: begin
                o_dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: accepts one instruction at a time,
// steps it through DECODE/EXEC/MEM/WB (or TRAP) and counts retirements.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 6,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    input  logic                  mem_ready,
    input  logic                  trap_ack,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [5:0]            branch_type,
    output logic                  is_load,
    output logic                  is_store,
    output logic                  is_lui,
    output logic                  is_jump,
    output logic                  mem_req,
    output logic                  reg_write,
    output logic                  pc_write,
    output logic                  illegal,
    output logic [CNT_W-1:0]      instret
);

    state_t                r_state;
    state_t                w_next_state;
    logic [31:0]           r_instr;
    decode_t               w_dec;
    logic                  w_accept;
    logic                  w_retire;
    logic [ALU_CTRL_W-1:0] r_alu_control;
    logic [BR_W-1:0]       r_branch_type;
    logic                  r_is_load;
    logic                  r_is_store;
    logic                  r_is_lui;
    logic                  r_is_jump;
    logic                  r_is_branch;
    logic [CNT_W-1:0]      r_instret;

    assign w_accept = (r_state == S_IDLE) && instr_valid;

    instr_decoder u_decoder (
        .i_instr (r_instr),
        .o_dec   (w_dec)
    );

    // State register; reset wins over any pending instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the per-state Moore strobes.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        instr_ready  = 1'b0;
        mem_req      = 1'b0;
        reg_write    = 1'b0;
        pc_write     = 1'b0;
        illegal      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next_state = w_dec.illegal ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                if (r_is_load || r_is_store) begin
                    w_next_state = S_MEM;
                end else if (r_is_branch) begin
                    pc_write     = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    if (r_is_load) begin
                        w_next_state = S_WB;
                    end else begin
                        w_retire     = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_WB: begin
                reg_write    = 1'b1;
                pc_write     = r_is_jump;
                w_retire     = 1'b1;
                w_next_state = S_IDLE;
            end
            S_TRAP: begin
                illegal = 1'b1;
                if (trap_ack) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Hold the accepted instruction word so the decoder sees a stable value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= '0;
        end else if (w_accept) begin
            r_instr <= instr;
        end
    end

    // Capture decode results on leaving DECODE; clear them whenever we head back to IDLE.
    always_ff @(posedge clk) begin
        if (reset || (w_next_state == S_IDLE)) begin
            r_alu_control <= '0;
            r_branch_type <= '0;
            r_is_load     <= 1'b0;
            r_is_store    <= 1'b0;
            r_is_lui      <= 1'b0;
            r_is_jump     <= 1'b0;
            r_is_branch   <= 1'b0;
        end else if ((r_state == S_DECODE) && !w_dec.illegal) begin
            r_alu_control <= ALU_CTRL_W'(w_dec.alu);
            r_branch_type <= w_dec.branch;
            r_is_load     <= w_dec.is_load;
            r_is_store    <= w_dec.is_store;
            r_is_lui      <= w_dec.is_lui;
            r_is_jump     <= w_dec.is_jump;
            r_is_branch   <= w_dec.is_branch;
        end
    end

    // Retired-instruction counter; wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign alu_control = r_alu_control;
    assign branch_type = r_branch_type;
    assign is_load     = r_is_load;
    assign is_store    = r_is_store;
    assign is_lui      = r_is_lui;
    assign is_jump     = r_is_jump;
    assign instret     = r_instret;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALU_CTRL_W, default 6, width of alu_control; minimum 5.
REQ-002 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 instr_valid  input  1  upstream instruction word available.
REQ-006 instr_ready  output  1  block can accept an instruction.
REQ-007 instr  input  32  RV32I instruction word.
REQ-008 mem_ready  input  1  data memory completes current access.
REQ-009 trap_ack  input  1  trap handler acknowledges illegal instruction.
REQ-010 alu_control  output  ALU_CTRL_W  ALU operation code.
REQ-011 branch_type  output  6  one-hot {bgeu,bltu,bge,blt,bne,beq}.
REQ-012 is_load, is_store, is_lui, is_jump  output  1 each  decoded class flags.
REQ-013 mem_req  output  1  data memory access request.
REQ-014 reg_write  output  1  register-file write strobe.
REQ-015 pc_write  output  1  PC update strobe.
REQ-016 illegal  output  1  illegal instruction trap pending.
REQ-017 instret  output  CNT_W  retired-instruction count.

Function
REQ-018 FSM states IDLE, DECODE, EXEC, MEM, WB, TRAP shall be implemented.
REQ-019 instr_ready shall be 1 only in IDLE; instruction accepted when instr_valid && instr_ready, latched, next state DECODE.
REQ-020 DECODE (1 cycle) shall register alu_control, branch_type, class flags; held unchanged until return to IDLE, cleared to 0 on IDLE entry.
REQ-021 alu_control shall be {zeros, imm_sel, alt, funct3}: imm_sel=1 for opcode 0010011, alt=funct7[5] for R-type and I-type shifts (funct3 001/101), else 0; loads/stores/LUI/jumps encode ADD (alt=0, funct3=000) with imm_sel=1.
REQ-022 Opcodes decoded: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 0110111 LUI, 1101111 JAL, 1100111 JALR.
REQ-023 Illegal: unknown opcode; R-type funct7 not 0000000/0100000; funct7=0100000 with funct3 not 000/101; branch funct3 010/011; DECODE then goes to TRAP.
REQ-024 EXEC: LOAD/STORE -> MEM; BRANCH -> IDLE with pc_write=1 for that cycle; R, I, LUI, JAL, JALR -> WB.
REQ-025 MEM: mem_req=1 every cycle in MEM; on mem_ready, LOAD -> WB, STORE -> IDLE; no timeout.
REQ-026 WB: reg_write=1 for exactly one cycle, pc_write=1 also for JAL/JALR, then IDLE.
REQ-027 Retirement: instret increments by 1 on the cycle leaving EXEC (branch), MEM (store) or WB; wraps to 0 at 2^CNT_W-1.
REQ-028 Latency from acceptance cycle 0: ALU op reg_write at cycle 3, instr_ready again at cycle 4; branch pc_write at cycle 2; load reg_write at cycle 3+N where N = MEM cycles.
REQ-029 TRAP: illegal=1 held; on trap_ack -> IDLE; trapped instruction not retired; trap_ack ignored outside TRAP.
REQ-030 mem_ready outside MEM shall be ignored.

Reset
REQ-031 reset shall force state IDLE; all outputs 0 and instret 0 at the next edge, except instr_ready=1 once in IDLE.
REQ-032 reset mid-instruction shall abort it: mem_req, reg_write, pc_write drop next cycle, no retire.
REQ-033 instr_valid during the reset cycle shall not be accepted.

Structure
REQ-034 Package ctrl_pkg shall hold opcode constants, state enum, branch one-hot bit indices, alu_control field positions.
REQ-035 Combinational sub-module instr_decoder shall map instr to decode fields and illegal flag; multicycle_ctrl registers them.

Verification
REQ-036 ADD (funct7=0, funct3=000, opcode 0110011) accepted cycle 0 -> alu_control=000000, reg_write at cycle 3 only, instret=1.
REQ-037 SRAI (funct7=0100000, funct3=101, opcode 0010011) -> alu_control=011101, reg_write pulse, no mem_req.
REQ-038 LW with mem_ready delayed 3 cycles -> mem_req high 4 cycles, reg_write one cycle after mem_ready, instret+1.
REQ-039 BNE (funct3=001) -> branch_type=000010, pc_write at cycle 2, no reg_write; funct3=010 -> illegal=1 until trap_ack, instret unchanged.
REQ-040 reset asserted during MEM with mem_ready=0 -> next cycle state IDLE, mem_req=0, instret unchanged.
REQ-041 CNT_W=4, 16 back-to-back ADDs -> instret wraps 15 -> 0.
